bht_update_scheduler: RTL and testbench

Sequencer and arbiter for the single-ported branch history table (BHT) in the fetch-stage predictor. It initialises every 2-bit counter after reset or flush, and queues counter updates from the decode stage. It also shares the one BHT access slot per cycle between fetch-stage lookups and those queued counter writes. It sits between the decode-stage branch resolution logic and the BHT array, and provides the fetch stage's permission to read.

---
 rtl/bht_update_scheduler.sv | 144 ++++++++++++++
 tb/tb_bht_update_scheduler.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/bht_update_scheduler.sv
// bht_update_scheduler
//   Owns the single BHT access slot. After reset or flush it walks every
//   entry writing 2'b01 (weakly not-taken). In RUN it queues decode-stage
//   counter updates and shares the slot between fetch lookups and queued
//   writes. A full queue forces a write so updates are never starved.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   flush           pulse: drop queued updates, restart the init walk
//   upd_*           decode-stage update offer (valid/ready handshake)
//   fetch_req       fetch wants the slot this cycle
//   fetch_grant     fetch may use the BHT read result
//   bht_we/windex/wdata  BHT write port
//   init_busy       initialisation walk in progress
//   pending         registered queue occupancy
module bht_update_scheduler #(
  parameter int INDEX_WIDTH = 10,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic                            upd_valid,
  input  logic [INDEX_WIDTH-1:0]          upd_index,
  input  logic [1:0]                      upd_state_old,
  input  logic                            upd_taken,
  output logic                            upd_ready,
  input  logic                            fetch_req,
  output logic                            fetch_grant,
  output logic                            bht_we,
  output logic [INDEX_WIDTH-1:0]          bht_windex,
  output logic [1:0]                      bht_wdata,
  output logic                            init_busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] pending
);

  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW-1:0]          DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]          CNT_ONE  = CW'(1);
  localparam logic [PW-1:0]          PTR_ONE  = PW'(1);
  localparam logic [INDEX_WIDTH-1:0] WALK_ONE = INDEX_WIDTH'(1);
  localparam logic [INDEX_WIDTH-1:0] WALK_END = {INDEX_WIDTH{1'b1}};

  typedef enum logic {INIT, RUN} state_t;

  typedef struct packed {
    logic [INDEX_WIDTH-1:0] index;
    logic [1:0]             ctr;
  } upd_t;

  state_t                 state, state_nxt;
  logic [INDEX_WIDTH-1:0] walk;
  logic [PW-1:0]          rd_ptr, wr_ptr;
  logic [CW-1:0]          count;
  upd_t                   mem [FIFO_DEPTH];

  logic full, empty, push, pop;
  logic [1:0] ctr_new;

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);

  // Saturating 2-bit counter step, computed once at enqueue time.
  always_comb begin
    ctr_new = upd_state_old;
    if (upd_taken) begin
      if (upd_state_old != 2'd3) ctr_new = upd_state_old + 2'd1;
    end else begin
      if (upd_state_old != 2'd0) ctr_new = upd_state_old - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= INIT;
    else     state <= state_nxt;
  end

  // Next state, slot arbitration and write-port mux. rst gates every
  // strobe so nothing leaks out during the reset cycle itself.
  always_comb begin
    state_nxt   = state;
    upd_ready   = 1'b0;
    fetch_grant = 1'b0;
    pop         = 1'b0;
    bht_we      = 1'b0;
    bht_windex  = walk;
    bht_wdata   = 2'b01;
    init_busy   = 1'b1;
    case (state)
      INIT: begin
        bht_we = !rst;
        if (flush)                 state_nxt = INIT;
        else if (walk == WALK_END) state_nxt = RUN;
      end
      RUN: begin
        init_busy  = rst;
        bht_windex = mem[rd_ptr].index;
        bht_wdata  = mem[rd_ptr].ctr;
        if (!rst) begin
          // ready is based on registered occupancy; a same-cycle pop
          // does not open a slot.
          upd_ready = !full;
          if (full)           pop = 1'b1;
          else if (fetch_req) fetch_grant = 1'b1;
          else if (!empty)    pop = 1'b1;
          bht_we = pop;
        end
        if (flush) state_nxt = INIT;
      end
      default: state_nxt = INIT;
    endcase
  end

  assign push    = upd_valid && upd_ready && !flush;
  assign pending = rst ? '0 : count;

  // Walk counter: held at 0 outside INIT so the next walk starts there.
  always_ff @(posedge clk) begin
    if (rst || flush || state == RUN) walk <= '0;
    else                              walk <= walk + WALK_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{index: upd_index, ctr: ctr_new};
  end

endmodule

// File: tb/tb_bht_update_scheduler.sv
module tb_bht_update_scheduler;
  localparam int IW = 3;
  localparam int D  = 4;
  localparam int N  = 1 << IW;

  logic          clk = 1'b0;
  logic          rst, flush, upd_valid, upd_taken, fetch_req;
  logic [IW-1:0] upd_index;
  logic [1:0]    upd_state_old;
  logic          upd_ready, fetch_grant, bht_we, init_busy;
  logic [IW-1:0] bht_windex;
  logic [1:0]    bht_wdata;
  logic [2:0]    pending;

  bht_update_scheduler #(.INDEX_WIDTH(IW), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .upd_valid(upd_valid), .upd_index(upd_index),
    .upd_state_old(upd_state_old), .upd_taken(upd_taken),
    .upd_ready(upd_ready), .fetch_req(fetch_req), .fetch_grant(fetch_grant),
    .bht_we(bht_we), .bht_windex(bht_windex), .bht_wdata(bht_wdata),
    .init_busy(init_busy), .pending(pending)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: table-walk position plus a plain queue of expected writes.
  typedef struct {int idx; int st;} exp_t;
  exp_t q[$];
  bit   m_init = 1'b1;
  int   m_walk = 0;

  function automatic int sat_step(input int old, input bit taken);
    int v;
    v = taken ? old + 1 : old - 1;
    if (v > 3) v = 3;
    if (v < 0) v = 0;
    return v;
  endfunction

  // Monitor: checks outputs mid-cycle, pops/pushes scoreboard, advances model.
  always @(negedge clk) begin
    int  n;
    bit  exp_we, exp_gnt;
    exp_t e;
    if (rst) begin
      chk("rst_we", bht_we, 0);
      chk("rst_grant", fetch_grant, 0);
      chk("rst_ready", upd_ready, 0);
      chk("rst_busy", init_busy, 1);
      chk("rst_pending", pending, 0);
      m_init = 1'b1;
      m_walk = 0;
      q.delete();
    end else if (m_init) begin
      chk("init_busy", init_busy, 1);
      chk("init_we", bht_we, 1);
      chk("init_windex", bht_windex, m_walk);
      chk("init_wdata", bht_wdata, 1);
      chk("init_ready", upd_ready, 0);
      chk("init_grant", fetch_grant, 0);
      chk("init_pending", pending, 0);
      if (flush)             m_walk = 0;
      else if (m_walk == N-1) m_init = 1'b0;
      else                   m_walk++;
    end else begin
      n       = q.size();
      exp_we  = (n == D) || (!fetch_req && n > 0);
      exp_gnt = fetch_req && (n < D);
      chk("run_busy", init_busy, 0);
      chk("run_pending", pending, n);
      chk("run_ready", upd_ready, int'(n < D));
      chk("run_grant", fetch_grant, int'(exp_gnt));
      chk("run_we", bht_we, int'(exp_we));
      if (exp_we) begin
        e = q.pop_front();
        if (bht_we) begin
          chk("run_windex", bht_windex, e.idx);
          chk("run_wdata", bht_wdata, e.st);
        end
      end
      if (flush) begin
        q.delete();
        m_init = 1'b1;
        m_walk = 0;
      end else if (upd_valid && n < D) begin
        q.push_back('{idx: int'(upd_index),
                      st: sat_step(int'(upd_state_old), upd_taken)});
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input int idx, input int old, input bit tk);
    upd_valid     = 1'b1;
    upd_index     = IW'(idx);
    upd_state_old = 2'(old);
    upd_taken     = tk;
  endtask

  task automatic idle();
    upd_valid = 1'b0;
    flush     = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; fetch_req = 1'b0;
    upd_valid = 1'b0; upd_index = '0; upd_state_old = '0; upd_taken = 1'b0;
    #1;
    cyc(); cyc();
    // Reset release and init walk, with updates offered that must be dropped.
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      offer(i, 2, 1'b1);
      cyc();
    end
    idle(); cyc();

    // Saturation cases, each written the cycle after acceptance.
    fetch_req = 1'b0;
    offer(5, 3, 1'b1); cyc();
    offer(2, 0, 1'b0); cyc();
    offer(1, 1, 1'b1); cyc();
    idle(); cyc(); cyc();

    // Arbitration: fetch holds the slot until the queue fills.
    fetch_req = 1'b1;
    for (int i = 0; i < D; i++) begin
      offer(i + 2, i, i[0]);
      cyc();
    end
    idle();
    for (int i = 0; i < 4; i++) cyc();

    // Simultaneous push/pop at pending=2.
    fetch_req = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
    fetch_req = 1'b1;
    offer(6, 1, 1'b0); cyc();
    offer(7, 2, 1'b1); cyc();
    fetch_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      offer(i, 3 - (i % 4), i[0]);
      cyc();
    end
    idle(); cyc(); cyc(); cyc();

    // Flush with three entries queued and a same-cycle offer.
    fetch_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      offer(i + 4, 1, 1'b1);
      cyc();
    end
    offer(3, 2, 1'b0); flush = 1'b1; cyc();
    idle();
    for (int i = 0; i < N + 2; i++) cyc();

    // Reset in the middle of a walk.
    flush = 1'b1; cyc();
    flush = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
    rst = 1'b1; cyc();
    rst = 1'b0;
    for (int i = 0; i < N + 2; i++) cyc();

    // Randomised traffic with occasional flush and reset.
    for (int i = 0; i < 3000; i++) begin
      fetch_req     = ($urandom_range(0, 99) < 55);
      upd_valid     = ($urandom_range(0, 99) < 60);
      upd_index     = IW'($urandom);
      upd_state_old = 2'($urandom);
      upd_taken     = 1'($urandom);
      flush         = ($urandom_range(0, 299) == 0);
      rst           = ($urandom_range(0, 599) == 0);
      cyc();
    end
    rst = 1'b0; idle(); fetch_req = 1'b0;
    for (int i = 0; i < N + D + 2; i++) cyc();

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
